rom_port_arbiter: RTL

- Shares the single read port of the combinational instruction ROM between two requesters: instruction fetch (IF) and the data-load unit (D), which reads .rodata.
- Each requester gets a valid/ready request channel and a one-entry registered response slot.
- Sits between the core front-end/LSU and the ROM instance: drives the ROM address, captures the instruction word returned by the ROM.
- Owns alignment and range checking.

---
 rtl/rom_arb_pkg.sv | 21 ++
 rtl/rom_rsp_slot.sv | 46 ++++
 rtl/rom_port_arbiter.sv | 120 ++++++++++++
 3 files changed

// File: rtl/rom_arb_pkg.sv
// Shared types and the address legality rule for the ROM port arbiter.
package rom_arb_pkg;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_IF   = 2'd1,
        GNT_D    = 2'd2
    } grant_e;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    // Byte address is legal when word aligned and its word index lies inside the ROM.
    // Callers zero-extend their address to 64 bits so one function serves any ADDR_W.
    function automatic logic addr_ok(input logic [63:0] addr, input logic [63:0] rom_words);
        return (addr[1:0] == 2'b00) && ((addr >> 2) < rom_words);
    endfunction

endpackage

// File: rtl/rom_rsp_slot.sv
// One-entry registered response slot: holds a ROM word and error flag until drained.
module rom_rsp_slot
    import rom_arb_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic              drain_i,
    input  logic              clear_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              err_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic              err_o
);

    slot_state_e       state_q;
    logic [DATA_W-1:0] data_q;
    logic              err_q;

    // Slot FSM: clear beats load beats drain; a load with a same-cycle drain stays FULL.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SLOT_EMPTY;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else if (clear_i) begin
            state_q <= SLOT_EMPTY;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else if (load_i) begin
            state_q <= SLOT_FULL;
            data_q  <= data_i;
            err_q   <= err_i;
        end else if (drain_i) begin
            state_q <= SLOT_EMPTY;
        end
    end

    assign valid_o = (state_q == SLOT_FULL);
    assign data_o  = data_q;
    assign err_o   = err_q;

endmodule

// File: rtl/rom_port_arbiter.sv
// Shares the combinational instruction ROM read port between instruction fetch
// and the data-load unit, with a starvation guard for fetch and one response slot each.
module rom_port_arbiter
    import rom_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int ROM_WORDS  = 1024,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              if_req_valid,
    input  logic [ADDR_W-1:0] if_req_addr,
    output logic              if_req_ready,
    output logic              if_rsp_valid,
    output logic [DATA_W-1:0] if_rsp_data,
    output logic              if_rsp_err,
    input  logic              if_rsp_ready,
    input  logic              d_req_valid,
    input  logic [ADDR_W-1:0] d_req_addr,
    output logic              d_req_ready,
    output logic              d_rsp_valid,
    output logic [DATA_W-1:0] d_rsp_data,
    output logic              d_rsp_err,
    input  logic              d_rsp_ready,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_inst
);

    localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    grant_e            grant;
    logic              if_elig, d_elig;
    logic              if_ok, d_ok;
    logic [CNT_W-1:0]  starve_q, starve_d;
    logic [ADDR_W-1:0] rom_addr_q;
    logic [DATA_W-1:0] if_load_data, d_load_data;

    // A slot is free when empty or being drained this very cycle.
    assign if_elig = if_req_valid && (!if_rsp_valid || if_rsp_ready) && !flush;
    assign d_elig  = d_req_valid  && (!d_rsp_valid  || d_rsp_ready);

    // Arbiter: D normally wins a tie; IF wins once it has lost STARVE_MAX times in a row.
    always_comb begin
        grant = GNT_NONE;
        if (if_elig && d_elig)
            grant = (starve_q == CNT_MAX) ? GNT_IF : GNT_D;
        else if (if_elig)
            grant = GNT_IF;
        else if (d_elig)
            grant = GNT_D;
    end

    assign if_req_ready = (grant == GNT_IF);
    assign d_req_ready  = (grant == GNT_D);

    // ROM address follows the winner; with no winner it parks on the last driven address.
    always_comb begin
        rom_addr = rom_addr_q;
        case (grant)
            GNT_IF:  rom_addr = if_req_addr;
            GNT_D:   rom_addr = d_req_addr;
            default: rom_addr = rom_addr_q;
        endcase
    end

    // Starvation count: grows only while IF is eligible and loses to D.
    always_comb begin
        starve_d = '0;
        if (if_elig && grant == GNT_D)
            starve_d = (starve_q == CNT_MAX) ? starve_q : starve_q + 1'b1;
    end

    // Registered state of the arbiter itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_q   <= '0;
            rom_addr_q <= '0;
        end else begin
            starve_q   <= starve_d;
            rom_addr_q <= rom_addr;
        end
    end

    // Illegal addresses still complete, but return a zero word flagged as an error.
    assign if_ok        = addr_ok(64'(if_req_addr), 64'(ROM_WORDS));
    assign d_ok         = addr_ok(64'(d_req_addr), 64'(ROM_WORDS));
    assign if_load_data = if_ok ? rom_inst : '0;
    assign d_load_data  = d_ok  ? rom_inst : '0;

    rom_rsp_slot #(.DATA_W(DATA_W)) u_if_slot (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (grant == GNT_IF),
        .drain_i (if_rsp_valid && if_rsp_ready),
        .clear_i (flush),
        .data_i  (if_load_data),
        .err_i   (!if_ok),
        .valid_o (if_rsp_valid),
        .data_o  (if_rsp_data),
        .err_o   (if_rsp_err)
    );

    rom_rsp_slot #(.DATA_W(DATA_W)) u_d_slot (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (grant == GNT_D),
        .drain_i (d_rsp_valid && d_rsp_ready),
        .clear_i (1'b0),
        .data_i  (d_load_data),
        .err_i   (!d_ok),
        .valid_o (d_rsp_valid),
        .data_o  (d_rsp_data),
        .err_o   (d_rsp_err)
    );

endmodule
